// File: rtl/mem_bus_controller.sv
// Memory bus controller: turns one cache-line request into a tagged burst on the
// 64-bit system bus, then returns the filled line or a write-complete pulse.
// Snoop-invalidate messages on the response channel become a one-cycle pulse.
module mem_bus_controller #(
  parameter int unsigned      BUS_W     = 64,
  parameter int unsigned      BEATS     = 8,
  parameter int unsigned      TAG_W     = 13,
  parameter logic [TAG_W-1:0] READ_TAG  = 13'h1100,
  parameter logic [TAG_W-1:0] WRITE_TAG = 13'h0100,
  parameter logic [TAG_W-1:0] INV_TAG   = 13'h0300
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BUS_W-1:0]       mem_address,
  input  logic [BUS_W*BEATS-1:0] mem_data_out,
  input  logic                   mem_req,
  input  logic                   mem_wr_en,
  output logic [BUS_W*BEATS-1:0] data_from_mem,
  output logic                   mem_data_valid,
  output logic                   invalidate_cache,
  output logic [BUS_W-1:0]       invalidate_cache_addr,
  output logic                   bus_reqcyc,
  output logic [BUS_W-1:0]       bus_req,
  output logic [TAG_W-1:0]       bus_reqtag,
  input  logic                   bus_reqack,
  input  logic                   bus_respcyc,
  input  logic [BUS_W-1:0]       bus_resp,
  input  logic [TAG_W-1:0]       bus_resptag,
  output logic                   bus_respack
);

  localparam int unsigned LINE_W = BUS_W * BEATS;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  // Byte-offset bits inside one line; forced to zero on every line address.
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdResp,
    StWrReq,
    StWrData,
    StDone
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  // Holds the write-back line for a write, and collects response beats for a read.
  logic [LINE_W-1:0]  r_line;
  logic [LINE_W-1:0]  r_data_from_mem;
  logic               r_mem_data_valid;
  logic               r_bus_reqcyc;
  logic [BUS_W-1:0]   r_bus_req;
  logic [TAG_W-1:0]   r_bus_reqtag;
  logic               r_inv;
  logic [BUS_W-1:0]   r_inv_addr;

  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BUS_W-1:0]   w_line_addr;
  logic               w_rd_beat;
  logic               w_inv_beat;
  logic               w_unused;

  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_line_addr = {mem_address[BUS_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_rd_beat   = bus_respcyc && (bus_resptag == READ_TAG);
  assign w_inv_beat  = bus_respcyc && (bus_resptag == INV_TAG);
  assign w_unused    = ^mem_address[OFF_W-1:0];

  // Every response beat is consumed, whatever its tag, except while in reset.
  assign bus_respack = bus_respcyc && rst;

  assign data_from_mem         = r_data_from_mem;
  assign mem_data_valid        = r_mem_data_valid;
  assign invalidate_cache      = r_inv;
  assign invalidate_cache_addr = r_inv_addr;
  assign bus_reqcyc            = r_bus_reqcyc;
  assign bus_req               = r_bus_req;
  assign bus_reqtag            = r_bus_reqtag;

  // Snoop path: independent of the burst FSM so it works mid-burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inv      <= 1'b0;
      r_inv_addr <= '0;
    end else begin
      r_inv <= w_inv_beat;
      if (w_inv_beat) begin
        r_inv_addr <= {bus_resp[BUS_W-1:OFF_W], {OFF_W{1'b0}}};
      end
    end
  end

  // Burst FSM with registered bus-request and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_line           <= '0;
      r_data_from_mem  <= '0;
      r_mem_data_valid <= 1'b0;
      r_bus_reqcyc     <= 1'b0;
      r_bus_req        <= '0;
      r_bus_reqtag     <= '0;
    end else begin
      r_mem_data_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (mem_req) begin
            r_line       <= mem_data_out;
            r_cnt        <= '0;
            r_bus_reqcyc <= 1'b1;
            r_bus_req    <= w_line_addr;
            if (mem_wr_en) begin
              r_bus_reqtag <= WRITE_TAG;
              r_state      <= StWrReq;
            end else begin
              r_bus_reqtag <= READ_TAG;
              r_state      <= StRdReq;
            end
          end
        end
        StRdReq: begin
          if (bus_reqack) begin
            r_bus_reqcyc <= 1'b0;
            r_bus_req    <= '0;
            r_bus_reqtag <= '0;
            r_state      <= StRdResp;
          end
        end
        StRdResp: begin
          if (w_rd_beat) begin
            r_line[r_cnt*BUS_W +: BUS_W] <= bus_resp;
            if (r_cnt == LAST_BEAT) begin
              r_cnt            <= '0;
              r_mem_data_valid <= 1'b1;
              // Last beat goes straight to the output alongside the buffered ones.
              r_data_from_mem  <= {bus_resp, r_line[LINE_W-BUS_W-1:0]};
              r_state          <= StDone;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        StWrReq: begin
          if (bus_reqack) begin
            r_cnt     <= '0;
            r_bus_req <= r_line[BUS_W-1:0];
            r_state   <= StWrData;
          end
        end
        StWrData: begin
          if (bus_reqack) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt            <= '0;
              r_bus_reqcyc     <= 1'b0;
              r_bus_req        <= '0;
              r_bus_reqtag     <= '0;
              r_mem_data_valid <= 1'b1;
              r_data_from_mem  <= '0;
              r_state          <= StDone;
            end else begin
              r_cnt     <= w_cnt_nxt;
              r_bus_req <= r_line[w_cnt_nxt*BUS_W +: BUS_W];
            end
          end
        end
        StDone: begin
          r_data_from_mem <= '0;
          r_state         <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
